// File: rtl/chunked_comparator_pkg.sv
// Shared types for the chunked comparator: FSM state and compare result encodings.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_GT,
    RES_LT,
    RES_EQ
  } result_t;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational magnitude compare of one CHUNK-bit slice pair.
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator, one CHUNK-bit slice per cycle, MSB-first with early exit.
// Optional COMPARATOR_SIGNED_EN adds a signed_mode input for two's-complement operands.
module chunked_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state, state_next;
  result_t          res;
  logic [IDX_W-1:0] idx, idx_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic             load, res_load;
  logic             s_gt, s_lt, s_eq;

  // Flipping the sign bit of both operands turns a signed compare into an unsigned one.
  always_comb begin
    msb_flip = '0;
`ifdef COMPARATOR_SIGNED_EN
    msb_flip[WIDTH-1] = signed_mode;
`endif
  end

  assign slice_a = a_reg[int'(idx)*CHUNK +: CHUNK];
  assign slice_b = b_reg[int'(idx)*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a  (slice_a),
    .b  (slice_b),
    .gt (s_gt),
    .lt (s_lt),
    .eq (s_eq)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    res_load   = 1'b0;
    res        = RES_EQ;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          idx_next   = IDX_W'(N - 1);
          state_next = COMPARE;
        end
      end
      COMPARE: begin
        if (s_gt) begin
          res        = RES_GT;
          res_load   = 1'b1;
          state_next = DONE;
        end else if (s_lt) begin
          res        = RES_LT;
          res_load   = 1'b1;
          state_next = DONE;
        end else if (s_eq && (idx == '0)) begin
          res        = RES_EQ;
          res_load   = 1'b1;
          state_next = DONE;
        end else begin
          idx_next = idx - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (load) begin
        a_reg <= a ^ msb_flip;
        b_reg <= b ^ msb_flip;
      end
      if (res_load) begin
        gt <= (res == RES_GT);
        lt <= (res == RES_LT);
        eq <= (res == RES_EQ);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/chunked_comparator.md
CHUNKED_COMPARATOR -- requirements
Module: chunked_comparator

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits.
REQ-002 SHALL have parameter: CHUNK, 8, bits compared per cycle; WIDTH % CHUNK == 0, CHUNK >= 1; N = WIDTH/CHUNK.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port: a  input  WIDTH  operand A; captured on accepted start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: gt  output  1  a > b for the last completed compare.
REQ-011 SHALL have port: lt  output  1  a < b for the last completed compare.
REQ-012 SHALL have port: eq  output  1  a == b for the last completed compare.

Function
REQ-013 SHALL implement FSM states IDLE, COMPARE and DONE.
REQ-014 SHALL, in IDLE with start=1, register a, b, set chunk index to N-1 (MS chunk) and go to COMPARE; start=0 stays IDLE.
REQ-015 SHALL compare in COMPARE one CHUNK-bit slice per cycle, MSB-first: slice_a > slice_b -> result gt, go DONE; slice_a < slice_b -> result lt, go DONE; equal with index 0 -> result eq, go DONE; equal otherwise -> decrement index, stay.
REQ-016 SHALL terminate early: k = cycles in COMPARE = position of first differing slice counted from MS (1..N), or N if equal.
REQ-017 SHALL fix latency: start sampled at edge t; done=1 during the cycle after edge t+k; total busy = k+1 cycles.
REQ-018 SHALL update gt/lt/eq on the edge entering DONE, with exactly one of them high; hold until the next entry into DONE.
REQ-019 SHALL assert done only in DONE (one cycle), DONE -> IDLE unconditionally.
REQ-020 SHALL ignore start in COMPARE and DONE; operand changes after capture do not affect the result.
REQ-021 SHALL, when CHUNK == WIDTH, decide in one COMPARE cycle (k=1).

Reset
REQ-022 SHALL, with n_rst=0, immediately force state IDLE, busy=0, done=0, gt=lt=eq=0, and clear operand/index registers, including mid-COMPARE; no result is produced for an aborted compare.
REQ-023 SHALL accept start on the first rising edge after n_rst deasserts.

Configuration
REQ-024 SHALL, with COMPARATOR_SIGNED_EN defined, add port signed_mode (input, 1) captured with start; when 1, operands are two's complement (MSB of top slice inverted before comparison); when 0, unsigned.
REQ-025 SHALL, without COMPARATOR_SIGNED_EN, omit signed_mode and compare unsigned only.

Structure
REQ-026 SHALL put the FSM state enum and the result enum (RES_GT, RES_LT, RES_EQ) in package comparator_pkg.
REQ-027 SHALL use one combinational sub-module, chunk_cmp (CHUNK-wide slice -> gt/lt/eq), instantiated once.
REQ-028 SHALL size the index register to max(1, $clog2(N)) bits.

Verification (WIDTH=32, CHUNK=8)
REQ-029 SHALL cover: a=0x1200_0000, b=0x1100_0000, start -> gt=1, lt=eq=0, done 2nd cycle after start edge (k=1).
REQ-030 SHALL cover: a=b=0xDEAD_BEEF -> eq=1, done 5th cycle, busy high 5 cycles.
REQ-031 SHALL cover: a=0x0000_00FF, b=0x0000_0100 -> lt=1, k=3, done 4th cycle.
REQ-032 SHALL cover: start re-pulsed with a=0, b=1 while busy on REQ-029 operands -> ignored; result gt; exactly one done.
REQ-033 SHALL cover: n_rst low during COMPARE of REQ-030 -> busy, done, gt, lt, eq 0 asynchronously; no done; next start a=5, b=5 -> eq.
REQ-034 SHALL cover, with COMPARATOR_SIGNED_EN: a=0xFFFF_FFFF, b=0x0000_0001, signed_mode=1 -> lt=1; signed_mode=0 -> gt=1.
